// File: rtl/riscv_pkg.sv
// Shared fetch-stage constants and the buffered fetch entry layout.
// Used by instr_fetch and fetch_fifo.
package riscv_pkg;

  localparam int INSTR_W = 32;
  localparam int PC_STEP = 4;
  // Low address bits that must be zero for a word fetch
  localparam logic [1:0] FETCH_ADDR_ALIGN = 2'b11;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [31:0]        pc;
  } fetch_entry;

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// In-order instruction buffer with synchronous flush.
// The head entry is read straight from storage, so outputs depend only on registers.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH   = 2,
  parameter int ENTRY_W = 64,
  parameter int CNT_W   = cnt_width(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic [ENTRY_W-1:0] push_data,
  input  logic               pop,
  input  logic               flush,
  output logic [ENTRY_W-1:0] head,
  output logic [CNT_W-1:0]   count,
  output logic               full,
  output logic               empty
);

  localparam int AW = $clog2(DEPTH);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic               do_pop;

  assign empty  = (count == '0);
  assign full   = (count == CNT_W'(DEPTH));
  assign do_pop = pop && !empty;
  assign head   = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(do_pop);
    end
  end

  // The issue credit in the parent reserves a slot per outstanding request
  always_ff @(posedge clk) begin
    if (!rst && !flush) assert (!(push && full));
  end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, issues word requests, buffers in-order responses, handles redirects.
// Optional FETCH_MISALIGN_CHECK_EN: misaligned redirect sets sticky fetch_misalign and halts fetch.
module instr_fetch
  import riscv_pkg::*;
#(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] RESET_PC   = '0,
  parameter int               FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [WIDTH-1:0]   imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  input  logic               redirect_valid,
  input  logic [WIDTH-1:0]   redirect_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [WIDTH-1:0]   instr_pc,
  output logic [WIDTH-1:0]   instr_pc_plus4
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic               fetch_misalign
`endif
);

  localparam int CNT_W   = cnt_width(FIFO_DEPTH);
  localparam int ENTRY_W = INSTR_W + WIDTH;

  logic [WIDTH-1:0]   pc;
  logic [CNT_W-1:0]   outstanding;
  logic [CNT_W-1:0]   drop;
  logic [CNT_W-1:0]   fifo_count;
  logic               fifo_full;
  logic               fifo_empty;
  logic [ENTRY_W-1:0] fifo_head;
  logic               credit_ok;
  logic               req_fire;
  logic               rsp_keep;
  logic               halted;
  logic [WIDTH-1:0]   redirect_target;

  assign redirect_target = redirect_pc & ~WIDTH'(FETCH_ADDR_ALIGN);

`ifdef FETCH_MISALIGN_CHECK_EN
  logic misalign_hit;
  assign misalign_hit = redirect_valid && ((redirect_pc[1:0] & FETCH_ADDR_ALIGN) != 2'b00);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)             halted <= 1'b0;
    else if (misalign_hit) halted <= 1'b1;
  end
  assign fetch_misalign = halted;
`else
  assign halted = 1'b0;
`endif

  // Responses already in flight count against buffer space
  assign credit_ok      = ({1'b0, fifo_count} + {1'b0, outstanding}) < (CNT_W+1)'(FIFO_DEPTH);
  assign imem_req_valid = !reset && !redirect_valid && !halted && credit_ok;
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign rsp_keep       = imem_rsp_valid && (drop == '0) && !redirect_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc          <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
    end else begin
      outstanding <= outstanding + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid);
      if (redirect_valid) begin
        pc   <= redirect_target;
        drop <= outstanding - CNT_W'(imem_rsp_valid);
      end else begin
        if (req_fire) pc <= pc + WIDTH'(PC_STEP);
        if (imem_rsp_valid && (drop != '0)) drop <= drop - 1'b1;
      end
    end
  end

  // Redirect discards this cycle's response alongside the flush; the pending
  // response remains tracked by outstanding/drop until it is received.
  fetch_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .ENTRY_W (ENTRY_W),
    .CNT_W   (CNT_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (reset),
    .push      (rsp_keep),
    .push_data ({imem_rsp_data, pc_of_rsp()}),
    .pop       (instr_ready),
    .flush     (redirect_valid),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Responses return in order, so the oldest outstanding address is the
  // current PC minus the in-flight byte span.
  function automatic logic [WIDTH-1:0] pc_of_rsp();
    return pc - WIDTH'(outstanding) * WIDTH'(PC_STEP);
  endfunction

  assign instr_valid    = !fifo_empty;
  assign instr          = fifo_empty ? '0 : fifo_head[ENTRY_W-1 -: INSTR_W];
  assign instr_pc       = fifo_empty ? '0 : fifo_head[WIDTH-1:0];
  assign instr_pc_plus4 = fifo_empty ? '0 : fifo_head[WIDTH-1:0] + WIDTH'(PC_STEP);

  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized self-checking bench for instr_fetch against a stream-level model
// of what decode must see (ordered PCs since the last redirect, data = memory image).
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset;
  always #5 clk = ~clk;

  logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic [31:0] imem_req_addr, imem_rsp_data;
  logic        redirect_valid, instr_valid, instr_ready;
  logic [31:0] redirect_pc, instr, instr_pc, instr_pc_plus4;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic        fetch_misalign, w_misalign;
`endif

  logic        w_req_valid, w_req_ready, w_rsp_valid, w_instr_valid;
  logic [31:0] w_req_addr, w_rsp_data, w_instr, w_instr_pc, w_pc_plus4;

  instr_fetch u_dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc), .instr_pc_plus4(instr_pc_plus4)
`ifdef FETCH_MISALIGN_CHECK_EN
    , .fetch_misalign(fetch_misalign)
`endif
  );

  instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .reset(reset),
    .imem_req_valid(w_req_valid), .imem_req_ready(w_req_ready),
    .imem_req_addr(w_req_addr), .imem_rsp_valid(w_rsp_valid),
    .imem_rsp_data(w_rsp_data), .redirect_valid(1'b0),
    .redirect_pc(32'h0), .instr_valid(w_instr_valid), .instr_ready(1'b0),
    .instr(w_instr), .instr_pc(w_instr_pc), .instr_pc_plus4(w_pc_plus4)
`ifdef FETCH_MISALIGN_CHECK_EN
    , .fetch_misalign(w_misalign)
`endif
  );

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } mreq_t;

  int          checks = 0;
  int          failures = 0;
  mreq_t       memq[$];
  logic [31:0] mq[$];
  int          epoch = 0;
  int          cyc = 0;
  int          last_due = 0;
  int          max_lat = 0;
  logic [31:0] next_addr = 32'h0;
  bit          halted_m = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_wrap();
    w_req_ready = 1'b0;
    w_rsp_valid = 1'b0;
    w_rsp_data  = 32'h0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    redirect_valid = 1'b0; redirect_pc = 32'h0; instr_ready = 1'b0;
    idle_wrap();
    #1;
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_instr_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_instr_pc", instr_pc, 32'h0);
    chk("rst_pc_plus4", instr_pc_plus4, 32'h0);
    chk("rst_wrap_pc_plus4", w_pc_plus4, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    memq.delete(); mq.delete();
    epoch++; next_addr = 32'h0; halted_m = 1'b0; last_due = cyc;
  endtask

  task automatic step(input bit redir, input logic [31:0] rpc, input bit iready, input bit rready);
    bit    rsp;
    bit    exp_rv;
    bit    mq_valid;
    mreq_t r;
    int    d;
    @(negedge clk);
    redirect_valid = redir; redirect_pc = rpc;
    instr_ready = iready; imem_req_ready = rready;
    rsp = (memq.size() > 0) && (memq[0].due <= cyc);
    imem_rsp_valid = rsp;
    imem_rsp_data  = rsp ? mem_word(memq[0].addr) : $urandom;
    #1;
    exp_rv   = !redir && !halted_m && ((mq.size() + memq.size()) < 2);
    mq_valid = mq.size() > 0;
    chk("req_valid", 32'(imem_req_valid), 32'(exp_rv));
    if (exp_rv) chk("req_addr", imem_req_addr, next_addr);
    chk("instr_valid", 32'(instr_valid), 32'(mq_valid));
    if (mq_valid) begin
      chk("instr_pc", instr_pc, mq[0]);
      chk("instr", instr, mem_word(mq[0]));
      chk("pc_plus4", instr_pc_plus4, mq[0] + 32'd4);
    end
`ifdef FETCH_MISALIGN_CHECK_EN
    chk("misalign", 32'(fetch_misalign), 32'(halted_m));
`endif
    if (rsp) r = memq.pop_front();
    if (redir) begin
      mq.delete();
      epoch++;
      next_addr = rpc & ~32'h3;
`ifdef FETCH_MISALIGN_CHECK_EN
      if (rpc[1:0] != 2'b00) halted_m = 1'b1;
`endif
    end else begin
      if (mq_valid && iready) void'(mq.pop_front());
      if (rsp && r.epoch == epoch) mq.push_back(r.addr);
      if (exp_rv && rready) begin
        d = cyc + 1 + $urandom_range(0, max_lat);
        if (d <= last_due) d = last_due + 1;
        last_due = d;
        memq.push_back('{addr: next_addr, epoch: epoch, due: d});
        next_addr = next_addr + 32'd4;
      end
    end
    cyc++;
  endtask

  initial begin
    reset = 1'b1;
    idle_wrap();
    do_reset();

    // Streaming with single-cycle memory
    max_lat = 0;
    repeat (12) step(1'b0, 32'h0, 1'b1, 1'b1);

    // Decode stalls: buffer fills, requests stop, then drain in order
    repeat (6) step(1'b0, 32'h0, 1'b0, 1'b1);
    repeat (8) step(1'b0, 32'h0, 1'b1, 1'b1);

    // Redirect with responses in flight
    max_lat = 3;
    repeat (4) step(1'b0, 32'h0, 1'b1, 1'b1);
    step(1'b1, 32'h100, 1'b1, 1'b1);
    repeat (10) step(1'b0, 32'h0, 1'b1, 1'b1);

    // Back-to-back redirects, last one wins
    step(1'b1, 32'h200, 1'b1, 1'b1);
    step(1'b1, 32'h300, 1'b1, 1'b1);
    repeat (8) step(1'b0, 32'h0, 1'b1, 1'b1);

    // Randomized traffic, redirects, stalls and latency
    for (int i = 0; i < 600; i++) begin
      if (i % 100 == 0) max_lat = $urandom_range(0, 3);
      step(($urandom_range(0, 99) < 6), $urandom & ~32'h3,
           ($urandom_range(0, 99) < 70), ($urandom_range(0, 99) < 80));
    end

    // Reset in the middle of traffic drops everything
    do_reset();
    max_lat = 1;
    repeat (40) step(($urandom_range(0, 99) < 5), $urandom & ~32'h3,
                     ($urandom_range(0, 99) < 75), 1'b1);

    // Misaligned redirect target
    repeat (3) step(1'b0, 32'h0, 1'b1, 1'b1);
    step(1'b1, 32'h102, 1'b1, 1'b1);
    repeat (8) step(1'b0, 32'h0, 1'b1, 1'b1);

    // PC wrap on the RESET_PC=0xFFFFFFFC instance
    @(negedge clk);
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; redirect_valid = 1'b0;
    #1;
    chk("wrap_req_valid", 32'(w_req_valid), 32'd1);
    chk("wrap_req_addr0", w_req_addr, 32'hFFFF_FFFC);
    w_req_ready = 1'b1;
    @(negedge clk);
    w_req_ready = 1'b0;
    w_rsp_valid = 1'b1;
    w_rsp_data  = mem_word(32'hFFFF_FFFC);
    #1;
    chk("wrap_req_addr1", w_req_addr, 32'h0);
    @(negedge clk);
    w_rsp_valid = 1'b0;
    #1;
    chk("wrap_instr_valid", 32'(w_instr_valid), 32'd1);
    chk("wrap_instr_pc", w_instr_pc, 32'hFFFF_FFFC);
    chk("wrap_pc_plus4", w_pc_plus4, 32'h0);
    chk("wrap_instr", w_instr, mem_word(32'hFFFF_FFFC));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
